switch_debounce: RTL

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 95 +++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - three-channel switch debouncer with 2-flop sync and per-channel qualify FSM
// Optional edge-pulse output sw_rise is enabled by defining SWITCH_DEBOUNCE_RISE_EN.
module switch_debounce #(
    parameter int DEBOUNCE_CNT = 4,
    parameter int CNT_WIDTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_in,
    output logic [2:0] sw_out,
`ifdef SWITCH_DEBOUNCE_RISE_EN
    output logic [2:0] sw_rise,
`endif
    output logic       stable
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(DEBOUNCE_CNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [2:0]           sync_meta;
    logic [2:0]           sync;
    state_t               state [3];
    logic [CNT_WIDTH-1:0] cnt   [3];
    logic [2:0]           accept;

    // A channel qualifies when it has held its new level for DEBOUNCE_CNT counted cycles.
    always_comb begin
        accept = 3'b000;
        for (int i = 0; i < 3; i++) begin
            accept[i] = (state[i] == PEND) && (sync[i] != sw_out[i]) && (cnt[i] == CNT_LIMIT);
        end
    end

    always_comb begin
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stable = stable & (state[i] == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 3'b000;
            sync      <= 3'b000;
            sw_out    <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync_meta <= sw_in;
            sync      <= sync_meta;
            for (int i = 0; i < 3; i++) begin
                case (state[i])
                    IDLE: begin
                        if (sync[i] != sw_out[i]) begin
                            state[i] <= PEND;
                            cnt[i]   <= CNT_ONE;
                        end
                    end
                    PEND: begin
                        if (sync[i] == sw_out[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (accept[i]) begin
                            sw_out[i] <= sync[i];
                            state[i]  <= IDLE;
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SWITCH_DEBOUNCE_RISE_EN
    // Pulse coincides with the first cycle sw_out reads the newly accepted 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_rise <= 3'b000;
        end else begin
            sw_rise <= accept & sync;
        end
    end
`endif

endmodule
